lzrw1_stream_sequencer: RTL

Front-end controller for decompressor_top. It accepts the raw LZRW1 compressed byte stream (control bytes interleaved with item bytes) over a valid/ready interface and splits it into literal and copy items. Each item is issued to the decompressor with its control bit, under the decompressor's busy handshake. It tracks stream boundaries, counts issued items, and reports completion or truncation.

---
 rtl/lzrw1_stream_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lzrw1_stream_sequencer.sv
// rtl/lzrw1_stream_sequencer.sv - splits an LZRW1 byte stream into literal/copy items for the decompressor
`timescale 1ns/1ps
module lzrw1_stream_sequencer #(
   parameter int CW_BITS     = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [7:0]             in_byte,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [15:0]            dec_data_in,
   output logic                   dec_control_word_in,
   output logic                   dec_data_in_valid,
   input  logic                   dec_busy,
   output logic [COUNT_WIDTH-1:0] items_issued,
   output logic                   done,
   output logic                   trunc_err
);

   // Item index width; the stream format fixes eight items per control byte.
   localparam int IDX_W = (CW_BITS > 1) ? $clog2(CW_BITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CW_BITS - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FETCH_CW  = 3'd1;
   localparam logic [2:0] ST_FETCH_B0  = 3'd2;
   localparam logic [2:0] ST_FETCH_B1  = 3'd3;
   localparam logic [2:0] ST_ISSUE     = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
   localparam logic [2:0] ST_FINISH    = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [CW_BITS-1:0]     ctrl_q, ctrl_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [7:0]             b0_q, b0_d;
   logic                   last_q, last_d;
   logic [15:0]            data_q, data_d;
   logic                   cw_q, cw_d;
   logic                   valid_q, valid_d;
   logic                   ready_q, ready_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   trunc_q, trunc_d;

   logic                   xfer;
   logic                   cur_bit;

   // Next-state logic: byte parsing, item issue handshake and stream bookkeeping.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      idx_d   = idx_q;
      b0_d    = b0_q;
      last_d  = last_q;
      data_d  = data_q;
      cw_d    = cw_q;
      cnt_d   = cnt_q;
      trunc_d = trunc_q;

      // in_ready is a register, so accepting a byte never depends combinationally on in_valid.
      xfer    = in_valid && ready_q;
      // Item k of a group uses control bit (CW_BITS-1-k): the MSB describes the first item.
      cur_bit = ctrl_q[IDX_LAST - idx_q];

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               trunc_d = 1'b0;
               state_d = ST_FETCH_CW;
            end
         end
         ST_FETCH_CW: begin
            if (xfer) begin
               ctrl_d  = CW_BITS'(in_byte);
               idx_d   = '0;
               // A control byte flagged last closes the stream with an empty group.
               state_d = in_last ? ST_FINISH : ST_FETCH_B0;
            end
         end
         ST_FETCH_B0: begin
            if (xfer) begin
               b0_d = in_byte;
               if (!cur_bit) begin
                  // Literal: the item is complete with this byte.
                  data_d  = {8'h00, in_byte};
                  cw_d    = 1'b0;
                  last_d  = in_last;
                  state_d = ST_ISSUE;
               end else if (in_last) begin
                  // Copy item cut off after its first byte: nothing is issued.
                  trunc_d = 1'b1;
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_FETCH_B1;
               end
            end
         end
         ST_FETCH_B1: begin
            if (xfer) begin
               data_d  = {b0_q, in_byte};
               cw_d    = 1'b1;
               last_d  = in_last;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Busy seen high, even on the first ISSUE cycle, means the item was taken.
            if (dec_busy) begin
               if (cnt_q != {COUNT_WIDTH{1'b1}}) begin
                  cnt_d = cnt_q + COUNT_WIDTH'(1);
               end
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            // The next item is only fetched once the decompressor has gone idle.
            if (!dec_busy) begin
               if (last_q) begin
                  state_d = ST_FINISH;
               end else if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_FETCH_CW;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_FETCH_B0;
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake outputs are registered decodes of the next state.
      ready_d = (state_d == ST_FETCH_CW) || (state_d == ST_FETCH_B0) || (state_d == ST_FETCH_B1);
      valid_d = (state_d == ST_ISSUE);
      done_d  = (state_d == ST_FINISH);
   end

   // State and output registers; reset aborts any stream in progress without a done pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         idx_q   <= '0;
         b0_q    <= '0;
         last_q  <= 1'b0;
         data_q  <= '0;
         cw_q    <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         idx_q   <= idx_d;
         b0_q    <= b0_d;
         last_q  <= last_d;
         data_q  <= data_d;
         cw_q    <= cw_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         trunc_q <= trunc_d;
      end
   end

   assign in_ready            = ready_q;
   assign dec_data_in         = data_q;
   assign dec_control_word_in = cw_q;
   assign dec_data_in_valid   = valid_q;
   assign items_issued        = cnt_q;
   assign done                = done_q;
   assign trunc_err           = trunc_q;

endmodule
